// File: rtl/branch_resolve_if.sv
// Fetch/EX side of the branch resolve unit: prediction push, resolution,
// redirect result and status. The unit itself attaches through the slave modport.
interface branch_resolve_if #(
  parameter int WORD_W = 32
);
  logic              push;
  logic [WORD_W-1:0] push_pc;
  logic              push_taken;
  logic [WORD_W-1:0] push_target;
  logic              resolve;
  logic              res_taken;
  logic [WORD_W-1:0] res_target;
  logic              flush_in;
  logic [1:0]        pred_result;
  logic              mispredict;
  logic [WORD_W-1:0] correct_pc;
  logic              full;
  logic              empty;
  logic [31:0]       branch_count;
  logic [31:0]       miss_count;
  logic              err_overflow;
  logic              err_underflow;

  modport master (
    output push, push_pc, push_taken, push_target,
    output resolve, res_taken, res_target, flush_in,
    input  pred_result, mispredict, correct_pc, full, empty,
    input  branch_count, miss_count, err_overflow, err_underflow
  );

  modport slave (
    input  push, push_pc, push_taken, push_target,
    input  resolve, res_taken, res_target, flush_in,
    output pred_result, mispredict, correct_pc, full, empty,
    output branch_count, miss_count, err_overflow, err_underflow
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of fetch-time branch predictions, checked against the EX
// outcome; emits RIGHT/WRONG training results and the mispredict redirect.
module branch_resolve_unit #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  branch_resolve_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] PRED_IDLE  = 2'b00;
  localparam logic [1:0] RIGHT_PRED = 2'b01;
  localparam logic [1:0] WRONG_PRED = 2'b10;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t            state_reg;
  logic [AW-1:0]     head_reg, tail_reg;
  logic [AW:0]       count_reg;
  logic [AW:0]       count_next;
  logic [WORD_W-1:0] pc_mem     [DEPTH];
  logic              taken_mem  [DEPTH];
  logic [WORD_W-1:0] target_mem [DEPTH];

  logic              head_taken;
  logic [WORD_W-1:0] head_pc, head_target;
  logic              full, empty;
  logic              pop, wrong, clear, push_ok, overflow;

  assign full  = (count_reg == FULL_CNT);
  assign empty = (count_reg == '0);
  assign bus.full  = full;
  assign bus.empty = empty;

  // Head entry is read combinationally so the outcome compares in the resolve cycle.
  assign head_pc     = pc_mem[head_reg];
  assign head_taken  = taken_mem[head_reg];
  assign head_target = target_mem[head_reg];

  assign pop   = bus.resolve && !empty;
  assign wrong = (bus.res_taken != head_taken) ||
                 (bus.res_taken && head_taken && (bus.res_target != head_target));
  assign clear = (pop && wrong) || bus.flush_in;

  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push_ok  = bus.push && (state_reg == RUN) && !clear && (!full || pop);
  assign overflow = bus.push && (state_reg == RUN) && !clear && full && !pop;

  assign count_next = count_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      pc_mem[tail_reg]     <= bus.push_pc;
      taken_mem[tail_reg]  <= bus.push_taken;
      target_mem[tail_reg] <= bus.push_target;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_reg         <= RUN;
      head_reg          <= '0;
      tail_reg          <= '0;
      count_reg         <= '0;
      bus.pred_result   <= PRED_IDLE;
      bus.mispredict    <= 1'b0;
      bus.correct_pc    <= '0;
      bus.branch_count  <= '0;
      bus.miss_count    <= '0;
      bus.err_overflow  <= 1'b0;
      bus.err_underflow <= 1'b0;
    end else begin
      if (clear) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (pop)     head_reg <= head_reg + 1'b1;
        if (push_ok) tail_reg <= tail_reg + 1'b1;
        count_reg <= count_next;
      end

      state_reg <= (pop && wrong) ? RECOVER : RUN;

      bus.pred_result <= pop ? (wrong ? WRONG_PRED : RIGHT_PRED) : PRED_IDLE;
      bus.mispredict  <= pop && wrong;
      if (pop)
        bus.correct_pc <= bus.res_taken ? bus.res_target : head_pc + WORD_W'(4);

      if (pop && (bus.branch_count != '1))
        bus.branch_count <= bus.branch_count + 32'd1;
      if (pop && wrong && (bus.miss_count != '1))
        bus.miss_count <= bus.miss_count + 32'd1;

      if (overflow)               bus.err_overflow  <= 1'b1;
      if (bus.resolve && empty)   bus.err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: correct/wrong resolves, full queue,
// wrong-path push discard, external flush, streaming and mid-run reset.
module tb_branch_resolve_unit;
  logic CLK = 1'b0;
  logic nRST;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 CLK = ~CLK;

  branch_resolve_if #(.WORD_W(32)) bus ();

  branch_resolve_unit #(.DEPTH(4), .WORD_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("  ok %s = %h", tag, got);
    end
  endtask

  // Advance one clock; outputs are sampled on the following falling edge.
  task automatic cycle();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    bus.push = 1'b0; bus.push_pc = '0; bus.push_taken = 1'b0; bus.push_target = '0;
    bus.resolve = 1'b0; bus.res_taken = 1'b0; bus.res_target = '0; bus.flush_in = 1'b0;
  endtask

  task automatic do_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    bus.push = 1'b1; bus.push_pc = pc; bus.push_taken = tk; bus.push_target = tg;
    cycle();
    bus.push = 1'b0;
  endtask

  task automatic do_resolve(input logic tk, input logic [31:0] tg);
    bus.resolve = 1'b1; bus.res_taken = tk; bus.res_target = tg;
    cycle();
    bus.resolve = 1'b0;
  endtask

  initial begin
    logic [31:0] pc, tg;
    logic        tk;

    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    cycle();
    check_val("rst pred_result", 32'(bus.pred_result), 32'h0);
    check_val("rst mispredict", 32'(bus.mispredict), 32'h0);
    check_val("rst correct_pc", bus.correct_pc, 32'h0);
    check_val("rst empty", 32'(bus.empty), 32'h1);
    check_val("rst full", 32'(bus.full), 32'h0);
    check_val("rst branch_count", bus.branch_count, 32'h0);
    check_val("rst errors", {30'h0, bus.err_overflow, bus.err_underflow}, 32'h0);
    nRST = 1'b1;

    // Single correct taken branch
    do_push(32'h100, 1'b1, 32'h120);
    check_val("t1 empty after push", 32'(bus.empty), 32'h0);
    do_resolve(1'b1, 32'h120);
    check_val("t1 pred_result", 32'(bus.pred_result), 32'h1);
    check_val("t1 mispredict", 32'(bus.mispredict), 32'h0);
    check_val("t1 branch_count", bus.branch_count, 32'h1);
    check_val("t1 empty", 32'(bus.empty), 32'h1);
    cycle();
    check_val("t1 pulse ends", 32'(bus.pred_result), 32'h0);

    // Predicted taken, actually not taken; next-cycle push lands in RECOVER
    do_push(32'h200, 1'b1, 32'h240);
    do_resolve(1'b0, 32'h999);
    check_val("t2 pred_result", 32'(bus.pred_result), 32'h2);
    check_val("t2 mispredict", 32'(bus.mispredict), 32'h1);
    check_val("t2 correct_pc", bus.correct_pc, 32'h204);
    check_val("t2 miss_count", bus.miss_count, 32'h1);
    do_push(32'h300, 1'b1, 32'h320);
    check_val("t2 recover push ignored", 32'(bus.empty), 32'h1);
    check_val("t2 mispredict drops", 32'(bus.mispredict), 32'h0);
    check_val("t2 correct_pc holds", bus.correct_pc, 32'h204);

    // Fill, overflow, drain in order (pointers wrap)
    for (int i = 0; i < 4; i++) begin
      pc = 32'h400 + 32'(16 * i);
      tk = i[0];
      do_push(pc, tk, tk ? pc + 32'h20 : pc + 32'h4);
    end
    check_val("t3 full", 32'(bus.full), 32'h1);
    check_val("t3 no overflow yet", 32'(bus.err_overflow), 32'h0);
    do_push(32'h4F0, 1'b1, 32'h500);
    check_val("t3 err_overflow", 32'(bus.err_overflow), 32'h1);
    check_val("t3 still full", 32'(bus.full), 32'h1);
    for (int i = 0; i < 4; i++) begin
      pc = 32'h400 + 32'(16 * i);
      tk = i[0];
      tg = tk ? pc + 32'h20 : pc + 32'h4;
      do_resolve(tk, tg);
      check_val($sformatf("t3 pred[%0d]", i), 32'(bus.pred_result), 32'h1);
      check_val($sformatf("t3 cpc[%0d]", i), bus.correct_pc, tk ? pc + 32'h20 : pc + 32'h4);
    end
    check_val("t3 empty", 32'(bus.empty), 32'h1);
    check_val("t3 branch_count", bus.branch_count, 32'h6);

    // Wrong resolve with a same-cycle push: queue clears, push dropped
    do_push(32'h500, 1'b0, 32'h504);
    do_push(32'h510, 1'b1, 32'h530);
    bus.push = 1'b1; bus.push_pc = 32'h600; bus.push_taken = 1'b1; bus.push_target = 32'h620;
    do_resolve(1'b1, 32'h340);
    bus.push = 1'b0;
    check_val("t4 pred_result", 32'(bus.pred_result), 32'h2);
    check_val("t4 correct_pc", bus.correct_pc, 32'h340);
    check_val("t4 empty", 32'(bus.empty), 32'h1);
    check_val("t4 miss_count", bus.miss_count, 32'h2);
    cycle();

    // External flush with 3 queued, then resolve on empty
    for (int i = 0; i < 3; i++) begin
      pc = 32'h700 + 32'(16 * i);
      do_push(pc, 1'b0, pc + 32'h4);
    end
    check_val("t5 no underflow yet", 32'(bus.err_underflow), 32'h0);
    bus.flush_in = 1'b1;
    cycle();
    bus.flush_in = 1'b0;
    check_val("t5 flush empty", 32'(bus.empty), 32'h1);
    check_val("t5 flush no pulse", 32'(bus.pred_result), 32'h0);
    do_resolve(1'b0, 32'h0);
    check_val("t5 err_underflow", 32'(bus.err_underflow), 32'h1);
    check_val("t5 no result", 32'(bus.pred_result), 32'h0);
    check_val("t5 branch_count", bus.branch_count, 32'h7);

    // Streaming: push and correct resolve every cycle, occupancy stays 1
    do_push(32'h800, 1'b1, 32'h900);
    for (int i = 0; i < 10; i++) begin
      pc = 32'h800 + 32'(16 * (i + 1));
      bus.push = 1'b1; bus.push_pc = pc; bus.push_taken = 1'b1; bus.push_target = pc + 32'h100;
      tg = 32'h800 + 32'(16 * i) + 32'h100;
      do_resolve(1'b1, tg);
      check_val($sformatf("t6 pred[%0d]", i), 32'(bus.pred_result), 32'h1);
      check_val($sformatf("t6 cpc[%0d]", i), bus.correct_pc, tg);
      check_val($sformatf("t6 occupancy[%0d]", i), {30'h0, bus.full, bus.empty}, 32'h0);
    end
    bus.push = 1'b0;
    check_val("t6 branch_count", bus.branch_count, 32'd17);
    check_val("t6 miss_count", bus.miss_count, 32'h2);

    // Reset with one entry still queued
    nRST = 1'b0;
    cycle();
    nRST = 1'b1;
    check_val("t7 empty", 32'(bus.empty), 32'h1);
    check_val("t7 counters", bus.branch_count | bus.miss_count, 32'h0);
    check_val("t7 errors", {30'h0, bus.err_overflow, bus.err_underflow}, 32'h0);
    do_resolve(1'b1, 32'h910);
    check_val("t7 nothing to resolve", 32'(bus.pred_result), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Resolution end of the 2-bit branch predictor interface. It records each conditional-branch prediction issued at fetch in an in-order queue. When the branch resolves in EX, it compares the actual outcome against the queued prediction and produces the RIGHT_PRED/WRONG_PRED result that trains the predictor. On a misprediction it drives the pipeline flush and the corrected PC, and it keeps branch and misprediction counters.

Parameters:
DEPTH, 4, queue entries (power of 2, >= 2)
WORD_W, 32, PC/target width

Ports:
CLK  in  1  clock
nRST  in  1  synchronous active-low reset
push  in  1  fetch issued a BREQ/BRNE prediction this cycle
push_pc  in  WORD_W  PC of that branch
push_taken  in  1  predicted taken
push_target  in  WORD_W  predicted target (pc+4+offset)
resolve  in  1  EX resolved the oldest outstanding branch
res_taken  in  1  actual outcome
res_target  in  WORD_W  actual branch target
flush_in  in  1  external flush (jump/exception); discards all outstanding entries
pred_result  out  2  00 idle, 01 RIGHT_PRED, 10 WRONG_PRED (package encoding); valid 1 cycle
mispredict  out  1  one-cycle flush request
correct_pc  out  WORD_W  redirect PC, valid with mispredict
full  out  1  count == DEPTH
empty  out  1  count == 0
branch_count  out  32  resolved branches, saturating
miss_count  out  32  mispredictions, saturating
err_overflow  out  1  sticky: push while full
err_underflow  out  1  sticky: resolve while empty

Behaviour:
- Reset (nRST low at posedge CLK) clears:
  - all outputs to 0 (pred_result = 00);
  - head/tail pointers and count to 0;
  - FSM to RUN.
  - Reset mid-operation discards queued entries with no result emitted.
- Queue is a circular FIFO of {pc, taken, target}.
  - Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
  - count is log2(DEPTH)+1 bits.
- Accepted push: push && !full && state==RUN && no clear this cycle.
  - Writes the entry at tail.
- Accepted resolve: resolve && !empty.
  - Reads and pops the head entry.
  - Wrong if res_taken != head.taken, or if both are taken and res_target != head.target; otherwise right.
- Outputs are registered and appear the cycle after an accepted resolve, for exactly one cycle:
  - pred_result = RIGHT_PRED or WRONG_PRED;
  - mispredict = 1 on wrong;
  - correct_pc = res_taken ? res_target : head.pc + 4 (WORD_W wrap);
  - all other cycles: pred_result = 00, mispredict = 0, correct_pc holds its last value.
- Clear condition: accepted resolve that is wrong, OR flush_in.
  - At that edge the queue empties (count = 0, head = tail = 0) after the pop.
  - A same-cycle push is discarded (wrong path). It does not set err_overflow.
- Simultaneous accepted push and correct resolve: both take effect, count unchanged. Push is accepted even when full if a pop occurs in the same cycle.
- flush_in together with resolve: the resolve is still evaluated and reported, then the queue clears.
- Rejected operations:
  - push while full with no same-cycle pop: dropped, err_overflow set.
  - resolve while empty: ignored, err_underflow set, no result emitted.
  - Sticky errors clear only on reset.
- FSM:
  - RUN -> RECOVER on a wrong resolve.
  - RECOVER -> RUN unconditionally after 1 cycle.
  - In RECOVER, push is ignored (fetch of the redirected PC has not yet issued); resolve is still honoured.
- Counters increment in the same cycle the result registers:
  - branch_count +1 per accepted resolve;
  - miss_count +1 per wrong resolve;
  - both saturate at 32'hFFFF_FFFF.
- full and empty are combinational from count.

Test Plan:
- Reset, push pc=0x100 taken=1 target=0x120, then resolve res_taken=1 res_target=0x120 -> next cycle pred_result=01, mispredict=0, branch_count=1, empty=1.
- Push pc=0x200 taken=1; resolve res_taken=0 -> pred_result=10, mispredict=1, correct_pc=0x204, miss_count=1; push in the following cycle ignored (RECOVER).
- Push 4 entries (full=1), push 5th -> err_overflow=1, count stays 4; resolve all 4 correct in order -> four RIGHT_PRED pulses, empty=1, pointers wrap to 0.
- 2 entries queued, first resolves wrong while push asserted same cycle -> queue empty, pushed entry dropped, correct_pc=res_target (0x340 when taken).
- flush_in with 3 entries queued -> empty=1 next cycle, no pred_result pulse; resolve afterwards -> err_underflow=1.
- Push and resolve every cycle with DEPTH=4 for 10 cycles, all correct -> count constant at 1, branch_count=10, miss_count=0.
